// File: rtl/flow_led_pkg.sv
// Shared types and start-pattern helper for the flowing-LED pattern engine.
package flow_led_pkg;

    typedef enum logic [1:0] {
        SHIFT_R = 2'd0,
        SHIFT_L = 2'd1,
        BOUNCE  = 2'd2,
        FILL    = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } led_state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;

    localparam int MAX_WIDTH = 32;

    // Start value of each pattern; callers keep the low `width` bits.
    function automatic logic [MAX_WIDTH-1:0] start_pattern(input led_mode_t mode, input int width);
        logic [MAX_WIDTH-1:0] msb;
        msb = '0;
        msb[width-1] = 1'b1;
        case (mode)
            SHIFT_R, BOUNCE: return msb;
            SHIFT_L:         return 32'd1;
            default:         return '0;
        endcase
    endfunction

endpackage

// File: rtl/flow_led_tick.sv
// Step-rate divider: pulses step once every speed+1 running cycles.
module flow_led_tick
    import flow_led_pkg::*;
#(
    parameter int SPEED_W = 4
) (
    input  logic               clk_bps,
    input  logic               rst,
    input  logic               clr,
    input  logic               run,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    logic [SPEED_W-1:0] cnt;

    // >= rather than == so lowering speed below the count steps immediately.
    assign step = run && (cnt >= speed);

    always_ff @(posedge clk_bps or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flow_led_engine.sv
// Run-time selectable LED pattern generator: shift right/left, bounce, bar-fill,
// with programmable step rate, freeze and a period-complete wrap pulse.
module flow_led_engine
    import flow_led_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int SPEED_W = 4
) (
    input  logic               clk_bps,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic               hold,
    output logic [WIDTH-1:0]   led,
    output logic               wrap
);

    localparam logic [WIDTH-1:0] LSB = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = LSB << (WIDTH - 1);

    led_state_t       state, state_nxt;
    led_mode_t        mode_in, mode_q;
    dir_t             dir, dir_nxt, step_dir;
    logic [WIDTH-1:0] led_nxt, step_led, start_cur, start_q;
    logic             wrap_nxt, step_wrap;
    logic             mode_chg, clr, run, step;
    logic             onehot, bar, going_right;

    assign mode_in   = led_mode_t'(mode);
    assign start_cur = WIDTH'(start_pattern(mode_in, WIDTH));
    assign start_q   = WIDTH'(start_pattern(mode_q, WIDTH));
    assign mode_chg  = (mode_in != mode_q);

    // Divider controls are derived without the step result to keep the loop open.
    assign clr = !en || (state == OFF) || mode_chg;
    assign run = en && (state == RUN) && !mode_chg && !hold;

    flow_led_tick #(.SPEED_W(SPEED_W)) u_tick (
        .clk_bps (clk_bps),
        .rst     (rst),
        .clr     (clr),
        .run     (run),
        .speed   (speed),
        .step    (step)
    );

    // Next pattern value if a step happens this edge.
    always_comb begin
        step_led    = led;
        step_dir    = dir;
        step_wrap   = 1'b0;
        going_right = 1'b0;
        onehot      = (led != '0) && ((led & (led - LSB)) == '0);
        bar         = ((~led) & ((~led) + LSB)) == '0;
        case (mode_q)
            SHIFT_R: begin
                if (!onehot) begin
                    step_led = start_q;
                end else if (led == LSB) begin
                    step_led  = start_q;
                    step_wrap = 1'b1;
                end else begin
                    step_led = led >> 1;
                end
            end
            SHIFT_L: begin
                if (!onehot) begin
                    step_led = start_q;
                end else if (led == MSB) begin
                    step_led  = start_q;
                    step_wrap = 1'b1;
                end else begin
                    step_led = led << 1;
                end
            end
            BOUNCE: begin
                if (!onehot) begin
                    step_led = start_q;
                    step_dir = RIGHT;
                end else begin
                    // An endpoint always forces the direction away from it.
                    going_right = ((dir == RIGHT) && !led[0]) || led[WIDTH-1];
                    step_led    = going_right ? (led >> 1) : (led << 1);
                    if (step_led[0]) begin
                        step_dir = LEFT;
                    end else if (step_led[WIDTH-1]) begin
                        step_dir  = RIGHT;
                        step_wrap = !going_right;
                    end else begin
                        step_dir = going_right ? RIGHT : LEFT;
                    end
                end
            end
            default: begin
                if (!bar) begin
                    step_led = start_q;
                end else if (&led) begin
                    step_led  = '0;
                    step_wrap = 1'b1;
                end else begin
                    step_led = (led >> 1) | MSB;
                end
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        dir_nxt   = dir;
        wrap_nxt  = 1'b0;
        if (!en) begin
            state_nxt = OFF;
            led_nxt   = '0;
            dir_nxt   = RIGHT;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = RUN;
                    led_nxt   = start_cur;
                    dir_nxt   = RIGHT;
                end
                RUN, HOLD: begin
                    if (mode_chg) begin
                        state_nxt = RUN;
                        led_nxt   = start_cur;
                        dir_nxt   = RIGHT;
                    end else if (hold) begin
                        state_nxt = HOLD;
                    end else if (state == HOLD) begin
                        state_nxt = RUN;
                    end else if (step) begin
                        led_nxt  = step_led;
                        dir_nxt  = step_dir;
                        wrap_nxt = step_wrap;
                    end
                end
                default: begin
                    state_nxt = OFF;
                    led_nxt   = '0;
                    dir_nxt   = RIGHT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_bps or posedge rst) begin
        if (rst) begin
            state  <= OFF;
            led    <= '0;
            dir    <= RIGHT;
            wrap   <= 1'b0;
            mode_q <= SHIFT_R;
        end else begin
            state  <= state_nxt;
            led    <= led_nxt;
            dir    <= dir_nxt;
            wrap   <= wrap_nxt;
            mode_q <= mode_in;
        end
    end

endmodule

// File: tb/tb_flow_led_engine.sv
// Self-checking bench for flow_led_engine: directed sequences plus randomized run
// compared every cycle against a position-index model of the patterns.
module tb_flow_led_engine;

    localparam int W  = 6;
    localparam int SW = 4;

    logic          clk_bps = 1'b0;
    logic          rst     = 1'b1;
    logic          en      = 1'b0;
    logic          hold    = 1'b0;
    logic [1:0]    mode    = 2'd0;
    logic [SW-1:0] speed   = '0;
    logic [W-1:0]  led;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    // Model: state 0=off 1=run 2=hold, idx = position within the pattern period.
    int   m_state = 0;
    int   m_idx   = 0;
    int   m_div   = 0;
    int   m_mode  = 0;
    logic m_wrap  = 1'b0;

    logic [W-1:0] shr_seq [7]  = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
                                  6'b000010, 6'b000001, 6'b100000};
    logic [W-1:0] bnc_seq [10] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010,
                                  6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000};
    logic [W-1:0] fil_seq [7]  = '{6'b000000, 6'b100000, 6'b110000, 6'b111000,
                                  6'b111100, 6'b111110, 6'b111111};

    flow_led_engine #(.WIDTH(W), .SPEED_W(SW)) dut (
        .clk_bps (clk_bps),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .speed   (speed),
        .hold    (hold),
        .led     (led),
        .wrap    (wrap)
    );

    always #5 clk_bps = ~clk_bps;

    function automatic int period(input int md);
        case (md)
            0, 1:    return W;
            2:       return 2 * (W - 1);
            default: return W + 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input int md, input int idx);
        int pos;
        int full;
        full = (1 << W) - 1;
        case (md)
            0:       pos = W - 1 - idx;
            1:       pos = idx;
            2:       pos = (idx < W) ? (W - 1 - idx) : (idx - (W - 1));
            default: return (idx == 0) ? '0 : W'(full ^ ((1 << (W - idx)) - 1));
        endcase
        return W'(1 << pos);
    endfunction

    function automatic logic [W-1:0] model_led();
        if (m_state == 0) return '0;
        return pat(m_mode, m_idx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_bps or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_idx   = 0;
            m_div   = 0;
            m_mode  = 0;
            m_wrap  = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (!en) begin
                m_state = 0;
                m_div   = 0;
            end else if (m_state == 0 || int'(mode) != m_mode) begin
                m_state = 1;
                m_idx   = 0;
                m_div   = 0;
            end else if (hold) begin
                m_state = 2;
            end else if (m_state == 2) begin
                m_state = 1;
            end else if (m_div >= int'(speed)) begin
                m_div  = 0;
                m_idx  = (m_idx + 1) % period(m_mode);
                m_wrap = (m_idx == 0);
            end else begin
                m_div++;
            end
            m_mode = int'(mode);
        end
    end

    always @(negedge clk_bps) begin
        if (!rst) begin
            chk("model_led", 32'(led), 32'(model_led()));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    task automatic tick();
        @(posedge clk_bps);
        #2;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);

        rst = 1'b0; en = 1'b1; mode = 2'd0; speed = '0; hold = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("shr_led", 32'(led), 32'(shr_seq[i]));
            chk("shr_wrap", 32'(wrap), 32'(i == 6));
        end

        mode = 2'd2;
        tick();
        chk("bnc_reload_led", 32'(led), 32'(6'b100000));
        chk("bnc_reload_wrap", 32'(wrap), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("bnc_led", 32'(led), 32'(bnc_seq[i % 10]));
            chk("bnc_wrap", 32'(wrap), 32'(i == 10));
        end

        mode = 2'd3; speed = SW'(2);
        tick();
        chk("fill_reload_led", 32'(led), 32'd0);
        for (int t = 1; t <= 21; t++) begin
            tick();
            chk("fill_led", 32'(led), 32'(fil_seq[(t / 3) % 7]));
            chk("fill_wrap", 32'(wrap), 32'(t == 21));
        end

        mode = 2'd1; speed = '0;
        repeat (3) tick();
        chk("shl_led", 32'(led), 32'(6'b000100));
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_led", 32'(led), 32'(6'b000100));
            chk("hold_wrap", 32'(wrap), 32'd0);
        end
        hold = 1'b0;
        tick();
        chk("unhold_led", 32'(led), 32'(6'b000100));
        tick();
        chk("resume_led", 32'(led), 32'(6'b001000));

        mode = 2'd0;
        repeat (3) tick();
        chk("pre_switch_led", 32'(led), 32'(6'b001000));
        mode = 2'd2;
        tick();
        chk("switch_led", 32'(led), 32'(6'b100000));
        chk("switch_wrap", 32'(wrap), 32'd0);
        tick();
        chk("switch_next_led", 32'(led), 32'(6'b010000));

        en = 1'b0;
        tick();
        chk("en_low_led", 32'(led), 32'd0);
        en = 1'b1;
        repeat (2) tick();
        chk("en_back_led", 32'(led), 32'(6'b010000));
        #1 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_led", 32'(led), 32'd0);
        tick();
        chk("post_rst_load_led", 32'(led), 32'(6'b100000));
        chk("post_rst_load_wrap", 32'(wrap), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            tick();
            en = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 99) < 4) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8) speed = SW'($urandom_range(0, 5));
            if ($urandom_range(0, 99) < 8) hold = ~hold;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 999) < 3) begin
                #1 rst = 1'b1;
                #1;
                chk("rand_rst_led", 32'(led), 32'd0);
                chk("rand_rst_wrap", 32'(wrap), 32'd0);
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
